// File: rtl/ysyx_25030093_wb_arbiter_pkg.sv
// rtl/ysyx_25030093_wb_arbiter_pkg.sv - shared constants for the writeback arbiter slice
// Purpose: writeback source indices and default geometry for the register-file
//          writeback arbiter, its interface and its round-robin sub-module.
// Ports:   none (package).
package ysyx_25030093_wb_arbiter_pkg;

  // Writeback source slots on the request vectors
  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_CSR = 2;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REQ    = 3;

endpackage

// File: rtl/ysyx_25030093_wb_arbiter_if.sv
// rtl/ysyx_25030093_wb_arbiter_if.sv - writeback/issue/register-file bundle
// Purpose: groups the writeback request handshake, the decode issue and
//          hazard-query signals and the register-file write port.
// Ports:   req_* (per-source writeback requests), iss_* (decode issue),
//          rs1/rs2 hazard queries, flush, rf_* write port, busy_vec debug.
//          Modport slave is the arbiter; modport master is its environment.
interface ysyx_25030093_wb_arbiter_if
  import ysyx_25030093_wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          iss_valid;
  logic [ADDR_WIDTH-1:0]         iss_rd;
  logic                          iss_ready;
  logic [ADDR_WIDTH-1:0]         rs1_addr;
  logic [ADDR_WIDTH-1:0]         rs2_addr;
  logic                          rs1_busy;
  logic                          rs2_busy;
  logic                          flush;
  logic                          rf_wen;
  logic [ADDR_WIDTH-1:0]         rf_waddr;
  logic [DATA_WIDTH-1:0]         rf_wdata;
  logic [(1<<ADDR_WIDTH)-1:0]    busy_vec;

  modport slave (
    input  req_valid, req_addr, req_data, iss_valid, iss_rd, rs1_addr, rs2_addr, flush,
    output req_ready, iss_ready, rs1_busy, rs2_busy, rf_wen, rf_waddr, rf_wdata, busy_vec
  );

  modport master (
    output req_valid, req_addr, req_data, iss_valid, iss_rd, rs1_addr, rs2_addr, flush,
    input  req_ready, iss_ready, rs1_busy, rs2_busy, rf_wen, rf_waddr, rf_wdata, busy_vec
  );

endinterface

// File: rtl/ysyx_25030093_rr_arbiter.sv
// rtl/ysyx_25030093_rr_arbiter.sv - round-robin arbiter with rotating pointer
// Purpose: one-hot grant among N requesters, priority starting after the last
//          accepted winner.
// Ports:   clock, reset (sync, active-high); req[N] requests; advance pulses
//          when the current grant is accepted; grant[N] one-hot or zero.
module ysyx_25030093_rr_arbiter
  import ysyx_25030093_wb_arbiter_pkg::*;
#(
  parameter int N = DEF_NUM_REQ
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;
  int            s;

  // Scan ptr+1, ptr+2, ... wrapping modulo N; first requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    s     = 0;
    for (int k = 1; k <= N; k++) begin
      s = int'(ptr_q) + k;
      if (s >= N) s = s - N;
      idx = PW'(s);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Pointer only moves on an accepted grant, so a stalled winner keeps priority.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      for (int i = 0; i < N; i++) begin
        if (grant[i]) ptr_d = PW'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= PW'(N - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ysyx_25030093_wb_arbiter.sv
// rtl/ysyx_25030093_wb_arbiter.sv - register-file writeback arbiter and scoreboard
// Purpose: shares the single register-file write port among NUM_REQ writeback
//          sources, registers the winning write for one cycle and tracks
//          destination registers with writes in flight for RAW/WAW stalls.
// Ports:   clock, reset (sync, active-high); bus (slave modport) carrying the
//          writeback requests, decode issue/hazard queries, flush and the
//          register-file write port.
module ysyx_25030093_wb_arbiter
  import ysyx_25030093_wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ
) (
  input logic                        clock,
  input logic                        reset,
  ysyx_25030093_wb_arbiter_if.slave  bus
);
  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    accept;
  logic                  advance;
  logic                  squash;
  logic                  iss_fire;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  assign squash = reset | bus.flush;

  ysyx_25030093_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     (bus.req_valid),
    .advance (advance),
    .grant   (grant)
  );

  assign bus.req_ready = squash ? '0 : grant;
  assign accept        = bus.req_valid & bus.req_ready;
  assign advance       = |accept;

  // accept is one-hot, so an OR-reduction acts as the mux.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        sel_addr = sel_addr | bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = sel_data | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // No bypass of a same-cycle clear: a busy destination always stalls issue.
  assign bus.iss_ready = ~squash & ((bus.iss_rd == '0) | ~busy_q[bus.iss_rd]);
  assign iss_fire      = bus.iss_valid & bus.iss_ready;

  // Output register drains every cycle; x0 writes are acked but never enabled.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (advance) begin
      rf_wen_d   = (sel_addr != '0);
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end
    if (bus.flush) begin
      rf_wen_d   = 1'b0;
      rf_waddr_d = '0;
      rf_wdata_d = '0;
    end
  end

  // Clear first, then set, so an issue to a register being written back wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
    if (iss_fire && (bus.iss_rd != '0)) busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
    if (bus.flush) busy_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  // A write still held when reset or flush arrives is squashed at that same
  // edge rather than reaching the register file.
  assign bus.rf_wen   = rf_wen_q & ~squash;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.busy_vec = busy_q;
  assign bus.rs1_busy = busy_q[bus.rs1_addr];
  assign bus.rs2_busy = busy_q[bus.rs2_addr];

endmodule

// File: tb/tb_ysyx_25030093_wb_arbiter.sv
// tb/tb_ysyx_25030093_wb_arbiter.sv - directed self-checking bench for the writeback arbiter
module tb_ysyx_25030093_wb_arbiter;
  import ysyx_25030093_wb_arbiter_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  ysyx_25030093_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  ysyx_25030093_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic half();
    @(negedge clock);
  endtask

  logic [2:0]  exp_g [4];
  logic [4:0]  exp_a [4];
  logic [31:0] exp_d [4];
  logic        seen2;

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_a = '{5'd1, 5'd2, 5'd3, 5'd1};
    exp_d = '{32'h11, 32'h22, 32'h33, 32'h11};

    // Reset: ready signals held low even with requests pending
    reset         = 1'b1;
    bus.req_valid = 3'b111;
    bus.req_addr  = {5'd3, 5'd2, 5'd1};
    bus.req_data  = {32'h33, 32'h22, 32'h11};
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd1;
    bus.rs1_addr  = 5'd0;
    bus.rs2_addr  = 5'd0;
    bus.flush     = 1'b0;
    tick();
    half();
    expect_eq("rst_req_ready", bus.req_ready, 3'b000);
    expect_eq("rst_iss_ready", bus.iss_ready, 1'b0);
    tick();
    reset         = 1'b0;
    bus.req_valid = 3'b000;
    bus.iss_valid = 1'b0;
    half();
    expect_eq("rst_rf_wen", bus.rf_wen, 1'b0);
    expect_eq("rst_rf_waddr", bus.rf_waddr, 5'd0);
    expect_eq("rst_rf_wdata", bus.rf_wdata, 32'd0);
    expect_eq("rst_busy_vec", bus.busy_vec, 32'd0);

    // Round-robin from reset: 0, 1, 2, 0
    tick();
    bus.req_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      half();
      expect_eq("rr_grant", bus.req_ready, exp_g[i]);
      if (i > 0) begin
        expect_eq("rr_wen", bus.rf_wen, 1'b1);
        expect_eq("rr_waddr", bus.rf_waddr, exp_a[i-1]);
        expect_eq("rr_wdata", bus.rf_wdata, exp_d[i-1]);
      end
      tick();
    end
    bus.req_valid = 3'b000;
    half();
    expect_eq("rr_last_wen", bus.rf_wen, 1'b1);
    expect_eq("rr_last_waddr", bus.rf_waddr, 5'd1);
    expect_eq("rr_last_wdata", bus.rf_wdata, 32'h11);
    tick();
    half();
    expect_eq("rr_drain_wen", bus.rf_wen, 1'b0);

    // Single-source latency on x5 via LSU
    tick();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd5;
    bus.rs1_addr  = 5'd5;
    half();
    expect_eq("lat_iss_ready", bus.iss_ready, 1'b1);
    expect_eq("lat_rs1_pre", bus.rs1_busy, 1'b0);
    tick();
    bus.iss_valid = 1'b0;
    half();
    expect_eq("lat_rs1_busy", bus.rs1_busy, 1'b1);
    expect_eq("lat_busy_vec", bus.busy_vec, 32'h0000_0020);
    bus.req_valid = 3'b010;
    bus.req_addr  = {5'd0, 5'd5, 5'd0};
    bus.req_data  = {32'h0, 32'hDEADBEEF, 32'h0};
    #1;
    expect_eq("lat_req_ready", bus.req_ready, 3'b010);
    tick();
    bus.req_valid = 3'b000;
    half();
    expect_eq("lat_wen", bus.rf_wen, 1'b1);
    expect_eq("lat_waddr", bus.rf_waddr, 5'd5);
    expect_eq("lat_wdata", bus.rf_wdata, 32'hDEADBEEF);
    expect_eq("lat_rs1_still", bus.rs1_busy, 1'b1);
    tick();
    half();
    expect_eq("lat_rs1_clear", bus.rs1_busy, 1'b0);
    expect_eq("lat_wen_off", bus.rf_wen, 1'b0);

    // WAW stall on x7
    tick();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd7;
    bus.rs2_addr  = 5'd7;
    tick();
    half();
    expect_eq("waw_busy_vec", bus.busy_vec, 32'h0000_0080);
    expect_eq("waw_rs2_busy", bus.rs2_busy, 1'b1);
    expect_eq("waw_stall0", bus.iss_ready, 1'b0);
    bus.req_valid = 3'b001;
    bus.req_addr  = {5'd0, 5'd0, 5'd7};
    bus.req_data  = {32'h0, 32'h0, 32'h77};
    #1;
    expect_eq("waw_req_ready", bus.req_ready, 3'b001);
    tick();
    bus.req_valid = 3'b000;
    half();
    expect_eq("waw_stall1", bus.iss_ready, 1'b0);
    expect_eq("waw_wen", bus.rf_wen, 1'b1);
    tick();
    half();
    expect_eq("waw_release", bus.iss_ready, 1'b1);
    // Same-cycle issue of x7 while x7 is being written back: set wins
    bus.iss_valid = 1'b0;
    bus.req_valid = 3'b001;
    bus.req_data  = {32'h0, 32'h0, 32'h78};
    tick();
    bus.req_valid = 3'b000;
    bus.iss_valid = 1'b1;
    half();
    expect_eq("waw_same_wen", bus.rf_wen, 1'b1);
    expect_eq("waw_same_iss", bus.iss_ready, 1'b1);
    tick();
    bus.iss_valid = 1'b0;
    half();
    expect_eq("waw_set_wins", bus.busy_vec, 32'h0000_0080);

    // Flush: issue x3 and x4, accept x3 write, flush the next cycle
    tick();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd3;
    tick();
    bus.iss_rd    = 5'd4;
    tick();
    bus.iss_valid = 1'b0;
    half();
    expect_eq("fl_busy_pre", bus.busy_vec, 32'h0000_0098);
    bus.req_valid = 3'b001;
    bus.req_addr  = {5'd0, 5'd0, 5'd3};
    bus.req_data  = {32'h0, 32'h0, 32'h3333};
    tick();
    bus.flush     = 1'b1;
    bus.req_addr  = {5'd0, 5'd0, 5'd9};
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd9;
    half();
    expect_eq("fl_wen", bus.rf_wen, 1'b0);
    expect_eq("fl_req_ready", bus.req_ready, 3'b000);
    expect_eq("fl_iss_ready", bus.iss_ready, 1'b0);
    tick();
    bus.flush     = 1'b0;
    bus.req_valid = 3'b000;
    bus.iss_valid = 1'b0;
    half();
    expect_eq("fl_busy_post", bus.busy_vec, 32'd0);
    expect_eq("fl_wen_post", bus.rf_wen, 1'b0);

    // x0 write: acked, dropped; issue to x0 never sets busy
    tick();
    bus.req_valid = 3'b001;
    bus.req_addr  = {5'd0, 5'd0, 5'd0};
    bus.req_data  = {32'h0, 32'h0, 32'h1234};
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd0;
    half();
    expect_eq("x0_req_ready", bus.req_ready, 3'b001);
    expect_eq("x0_iss_ready", bus.iss_ready, 1'b1);
    tick();
    bus.req_valid = 3'b000;
    bus.iss_valid = 1'b0;
    half();
    expect_eq("x0_wen", bus.rf_wen, 1'b0);
    expect_eq("x0_busy_vec", bus.busy_vec, 32'd0);

    // Fairness: source 0 held valid, source 2 asserts once
    tick();
    bus.req_valid = 3'b001;
    bus.req_addr  = {5'd12, 5'd0, 5'd10};
    bus.req_data  = {32'hC0, 32'h0, 32'hA0};
    half();
    expect_eq("fair_src0", bus.req_ready, 3'b001);
    tick();
    bus.req_valid = 3'b101;
    seen2 = 1'b0;
    for (int c = 0; c < NR && !seen2; c++) begin
      half();
      if (bus.req_ready[SRC_CSR]) seen2 = 1'b1;
      tick();
    end
    expect_eq("fair_src2_granted", seen2, 1'b1);
    bus.req_valid = 3'b001;
    half();
    expect_eq("fair_src2_waddr", bus.rf_waddr, 5'd12);
    expect_eq("fair_src2_wdata", bus.rf_wdata, 32'hC0);
    expect_eq("fair_back_to_0", bus.req_ready, 3'b001);
    tick();
    bus.req_valid = 3'b000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
